// File: rtl/mul4_seq_ctrl.sv
// 4x4 unsigned shift-and-add multiplier with a TEST/ADD/SHIFT control FSM.
// One partial-product bit is retired per SHIFT; product updates only on completion.
module mul4_seq_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] product,
    output logic [2:0] state,
    output logic       sh_s1,
    output logic       sh_s0,
    output logic       acc_ld,
    output logic       cnt_en,
    output logic [1:0] cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TEST  = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_e;

    state_e     state_q;
    logic [3:0] mcand_q;
    logic [7:0] p_q;
    logic       c_q;
    logic [1:0] cnt_q;
    logic [7:0] product_q;

    logic [4:0] sum_d;
    logic [7:0] p_shift_d;

    // The upper half plus multiplicand keeps its carry so 15*15 cannot overflow.
    assign sum_d     = {1'b0, p_q[7:4]} + {1'b0, mcand_q};
    assign p_shift_d = {c_q, p_q[7:1]};

    // NOTE: all state updates use non-blocking assignments so every branch
    // reads the pre-edge values of p_q, c_q and cnt_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= 4'd0;
            p_q       <= 8'd0;
            c_q       <= 1'b0;
            cnt_q     <= 2'd0;
            product_q <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mcand_q <= a;
                        p_q     <= {4'b0, b};
                        c_q     <= 1'b0;
                        cnt_q   <= 2'd0;
                        state_q <= TEST;
                    end
                end
                TEST: state_q <= p_q[0] ? ADD : SHIFT;
                ADD: begin
                    c_q      <= sum_d[4];
                    p_q[7:4] <= sum_d[3:0];
                    state_q  <= SHIFT;
                end
                SHIFT: begin
                    p_q <= p_shift_d;
                    c_q <= 1'b0;
                    if (cnt_q == 2'd3) begin
                        product_q <= p_shift_d;
                        state_q   <= DONE;
                    end else begin
                        cnt_q   <= cnt_q + 2'd1;
                        state_q <= TEST;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: every strobe gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        sh_s1  = 1'b0;
        sh_s0  = 1'b0;
        acc_ld = 1'b0;
        cnt_en = 1'b0;
        case (state_q)
            IDLE: begin
                sh_s1 = start && !rst;
                sh_s0 = start && !rst;
            end
            ADD:   acc_ld = 1'b1;
            SHIFT: begin
                sh_s0  = 1'b1;
                cnt_en = 1'b1;
            end
            default: ;
        endcase
    end

    assign state   = state_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign product = product_q;
    assign cnt     = cnt_q;

endmodule

// File: tb/tb_mul4_seq_ctrl.sv
// Scenario-driven bench for mul4_seq_ctrl: expected products are queued when an
// operation is launched and compared when done pulses.
module tb_mul4_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] product;
    logic [2:0] state;
    logic       sh_s1;
    logic       sh_s0;
    logic       acc_ld;
    logic       cnt_en;
    logic [1:0] cnt;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb_q[$];
    logic [7:0] last_product = 8'd0;

    mul4_seq_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .state   (state),
        .sh_s1   (sh_s1),
        .sh_s0   (sh_s0),
        .acc_ld  (acc_ld),
        .cnt_en  (cnt_en),
        .cnt     (cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Watches one operation from the cycle after the accepting edge until done.
    task automatic watch_op(input string name, input int exp_lat, input int exp_add,
                            input int poke_n, input logic [3:0] poke_a, input bit poke_start);
        int         adds = 0;
        int         shifts = 0;
        bit         seen = 0;
        bit         hold_bad = 0;
        bit         busy_bad = 0;
        bit         strobe_bad = 0;
        logic [7:0] exp_p;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                checks++;
                if (n !== exp_lat) begin
                    errors++;
                    $display("FAIL %s_latency: done after %0d edges, expected %0d", name, n, exp_lat);
                end
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s_unexpected_done: product %02h with empty scoreboard", name, product);
                end else begin
                    exp_p = sb_q.pop_front();
                    if (product !== exp_p) begin
                        errors++;
                        $display("FAIL %s_product: got %02h expected %02h", name, product, exp_p);
                    end
                    last_product = exp_p;
                end
                if (busy !== 1'b1 || state !== 3'd4 || sh_s1 !== 1'b0 || sh_s0 !== 1'b0) busy_bad = 1;
            end else begin
                if (acc_ld === 1'b1) adds++;
                if (cnt_en === 1'b1) shifts++;
                if (product !== last_product) hold_bad = 1;
                if (busy !== 1'b1) busy_bad = 1;
                if (sh_s1 !== 1'b0 || sh_s0 !== cnt_en || (acc_ld && cnt_en)) strobe_bad = 1;
                if (n == poke_n) begin
                    a = poke_a;
                    if (poke_start) begin
                        b = ~b;
                        start = 1'b1;
                    end
                end
                if (n == poke_n + 1 && poke_start) start = 1'b0;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: no done within 40 cycles, expected at %0d", name, exp_lat);
        end
        checks++;
        if (adds !== exp_add) begin
            errors++;
            $display("FAIL %s_acc_ld_count: got %0d expected %0d", name, adds, exp_add);
        end
        checks++;
        if (shifts !== 4) begin
            errors++;
            $display("FAIL %s_cnt_en_count: got %0d expected 4", name, shifts);
        end
        checks++;
        if (hold_bad || busy_bad || strobe_bad) begin
            errors++;
            $display("FAIL %s_in_flight: hold_bad %0d busy_bad %0d strobe_bad %0d expected 0 0 0",
                     name, hold_bad, busy_bad, strobe_bad);
        end
    endtask

    task automatic run_op(input string name, input logic [3:0] ai, input logic [3:0] bi,
                          input int poke_n, input logic [3:0] poke_a, input bit poke_start);
        @(negedge clk);
        a = ai;
        b = bi;
        start = 1'b1;
        sb_q.push_back(8'(ai) * 8'(bi));
        @(posedge clk);
        #1 start = 1'b0;
        watch_op(name, 8 + $countones(bi), $countones(bi), poke_n, poke_a, poke_start);
        @(negedge clk);
        checks++;
        if (state !== 3'd0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_after_done: state %0d done %b busy %b expected 0 0 0", name, state, done, busy);
        end
    endtask

    task automatic test_reset;
        start = 1'b0;
        a = 4'd0;
        b = 4'd0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (state !== 3'd0 || product !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || cnt !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: state %0d product %02h busy %b done %b cnt %0d expected 0 00 0 0 0",
                     state, product, busy, done, cnt);
        end
        checks++;
        if ({sh_s1, sh_s0, acc_ld, cnt_en} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes: got %b expected 0000", {sh_s1, sh_s0, acc_ld, cnt_en});
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (state !== 3'd0 || product !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: state %0d product %02h busy %b expected 0 00 0", state, product, busy);
        end
        last_product = 8'h00;
    endtask

    task automatic test_basic;
        run_op("mul_3x5", 4'd3, 4'd5, -10, 4'd0, 1'b0);
        run_op("mul_15x15", 4'd15, 4'd15, -10, 4'd0, 1'b0);
        run_op("mul_9x0", 4'd9, 4'd0, -10, 4'd0, 1'b0);
    endtask

    task automatic test_boundaries;
        logic [3:0] ta[4] = '{4'd0, 4'd15, 4'd1, 4'd8};
        logic [3:0] tb_v[4] = '{4'd0, 4'd1, 4'd15, 4'd8};
        for (int i = 0; i < 4; i++) run_op($sformatf("bound_%0d", i), ta[i], tb_v[i], -10, 4'd0, 1'b0);
    endtask

    task automatic test_busy_ignore;
        bit extra = 0;
        // a/b scrambled and start pulsed mid-operation must neither alter nor queue anything
        run_op("busy_ignore", 4'd11, 4'd6, 4, 4'd2, 1'b1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (state !== 3'd0 || done !== 1'b0) extra = 1;
        end
        checks++;
        if (extra || product !== last_product) begin
            errors++;
            $display("FAIL busy_no_queue: extra op %0d product %02h expected 0 %02h", extra, product, last_product);
        end
    endtask

    task automatic test_back_to_back;
        bit extra = 0;
        @(negedge clk);
        a = 4'd2;
        b = 4'd3;
        start = 1'b1;
        sb_q.push_back(8'h06);
        @(posedge clk);
        watch_op("b2b_first", 10, 2, 3, 4'd7, 1'b0);
        @(negedge clk);
        checks++;
        if (state !== 3'd0 || busy !== 1'b0 || sh_s1 !== 1'b1 || sh_s0 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle_gap: state %0d busy %b sh %b%b expected 0 0 11", state, busy, sh_s1, sh_s0);
        end
        sb_q.push_back(8'h15);
        @(posedge clk);
        #1 start = 1'b0;
        watch_op("b2b_second", 10, 2, -10, 4'd0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || state !== 3'd0) extra = 1;
        end
        checks++;
        if (extra) begin
            errors++;
            $display("FAIL b2b_extra_op: got extra activity 1 expected 0");
        end
    endtask

    task automatic test_reset_mid_op;
        bit stray_done = 0;
        @(negedge clk);
        a = 4'd6;
        b = 4'd1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (state !== 3'd2 || acc_ld !== 1'b1) begin
            errors++;
            $display("FAIL abort_in_add: state %0d acc_ld %b expected 2 1", state, acc_ld);
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== 3'd0 || product !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_cleared: state %0d product %02h busy %b done %b expected 0 00 0 0",
                     state, product, busy, done);
        end
        last_product = 8'h00;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || product !== 8'h00) stray_done = 1;
        end
        checks++;
        if (stray_done) begin
            errors++;
            $display("FAIL abort_no_done: got stray done/product 1 expected 0");
        end
        run_op("after_abort_6x1", 4'd6, 4'd1, -10, 4'd0, 1'b0);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_boundaries;
        test_busy_ignore;
        test_back_to_back;
        test_reset_mid_op;
        checks++;
        if (sb_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
